// File: rtl/fadd_wb_queue.sv
// fadd_wb_queue
// ------------------------------------------------------------------------
// Writeback buffer between the FP16-style add pipe and the register-file
// writeback port. Each add result is buffered together with its control
// sideband in a small in-order FIFO. The head entry is shown on the wb_*
// port with valid/ready handshaking. As each entry retires, its exception
// flags are ORed into a sticky flag register belonging to its warp.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid_i / in_ready_o   upstream handshake (add pipe result)
//   result_i, fflags_i        result word and its exception flags
//   ctrl_c_i, ctrl_reg_idxw_i, ctrl_warpid_i   control sideband
//   wb_valid_o / wb_ready_i   writeback handshake for the head entry
//   wb_data_o, wb_ctrl_c_o, wb_reg_idxw_o, wb_warpid_o   head entry fields
//   count_o                   current occupancy
//   fflags_rd_warpid_i / fflags_rd_o   sticky flag read (combinational)
//   fflags_clr_i / fflags_clr_warpid_i clear the sticky flags of one warp
// ------------------------------------------------------------------------
module fadd_wb_queue #(
  parameter int EXPWIDTH     = 5,
  parameter int PRECISION    = 3,
  parameter int CTRL_C_WIDTH = 16,
  parameter int DEPTH_WARP   = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [EXPWIDTH+PRECISION:0]       result_i,
  input  logic [4:0]                        fflags_i,
  input  logic [CTRL_C_WIDTH-1:0]           ctrl_c_i,
  input  logic [7:0]                        ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]             ctrl_warpid_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [EXPWIDTH+PRECISION:0]       wb_data_o,
  output logic [CTRL_C_WIDTH-1:0]           wb_ctrl_c_o,
  output logic [7:0]                        wb_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]             wb_warpid_o,
  output logic [$clog2(FIFO_DEPTH):0]       count_o,
  input  logic [DEPTH_WARP-1:0]             fflags_rd_warpid_i,
  output logic [4:0]                        fflags_rd_o,
  input  logic                              fflags_clr_i,
  input  logic [DEPTH_WARP-1:0]             fflags_clr_warpid_i
);

  localparam int W  = EXPWIDTH + PRECISION + 1;
  localparam int NW = 1 << DEPTH_WARP;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Entry storage, one array per field
  logic [W-1:0]            mem_data   [FIFO_DEPTH];
  logic [4:0]              mem_fflags [FIFO_DEPTH];
  logic [CTRL_C_WIDTH-1:0] mem_ctrl_c [FIFO_DEPTH];
  logic [7:0]              mem_reg    [FIFO_DEPTH];
  logic [DEPTH_WARP-1:0]   mem_warpid [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    sticky [NW];

  logic          push;
  logic          pop;
  logic [PW-1:0] head_idx;
  logic [4:0]    head_fflags;

  // Handshake terms. in_ready depends only on the registered count, so a
  // full queue stays not-ready even in a cycle where the head is popped.
  always_comb begin
    in_ready_o = (count != CW'(FIFO_DEPTH));
    wb_valid_o = (count != '0);
    push       = in_valid_i & in_ready_o;
    pop        = wb_valid_o & wb_ready_i;
  end

  // When the queue is empty the wb_* fields point one slot behind rd_ptr,
  // which holds the most recently popped entry (all zero after reset).
  always_comb begin
    head_idx      = (count == '0) ? (rd_ptr - PW'(1)) : rd_ptr;
    wb_data_o     = mem_data[head_idx];
    wb_ctrl_c_o   = mem_ctrl_c[head_idx];
    wb_reg_idxw_o = mem_reg[head_idx];
    wb_warpid_o   = mem_warpid[head_idx];
    head_fflags   = mem_fflags[head_idx];
    count_o       = count;
    fflags_rd_o   = sticky[fflags_rd_warpid_i];
  end

  // Entry storage and write pointer; reset zeroes every slot so the wb_*
  // fields read back as zero until the first entry retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i]   <= '0;
        mem_fflags[i] <= '0;
        mem_ctrl_c[i] <= '0;
        mem_reg[i]    <= '0;
        mem_warpid[i] <= '0;
      end
    end else if (push) begin
      mem_data[wr_ptr]   <= result_i;
      mem_fflags[wr_ptr] <= fflags_i;
      mem_ctrl_c[wr_ptr] <= ctrl_c_i;
      mem_reg[wr_ptr]    <= ctrl_reg_idxw_i;
      mem_warpid[wr_ptr] <= ctrl_warpid_i;
      wr_ptr             <= wr_ptr + PW'(1);
    end
  end

  // Read pointer and occupancy. Pointers wrap naturally because the depth
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags per warp. A clear and a pop on the same warp in one cycle
  // leave exactly the popped entry's flags: the clear wipes the old value
  // first, then the retiring flags are ORed in.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NW; w++) begin
        sticky[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        sticky[w] <= ((fflags_clr_i && (fflags_clr_warpid_i == DEPTH_WARP'(w)))
                       ? 5'b0 : sticky[w])
                   | ((pop && (wb_warpid_o == DEPTH_WARP'(w)))
                       ? head_fflags : 5'b0);
      end
    end
  end

endmodule

// File: tb/tb_fadd_wb_queue.sv
// tb_fadd_wb_queue
// ------------------------------------------------------------------------
// Directed testbench for fadd_wb_queue with the default parameters
// (9-bit result, 16-bit ctrl_c, 16 warps, 4-entry queue). Inputs change
// 1 ns after each rising edge and outputs are checked at that point,
// once registered state has settled.
// ------------------------------------------------------------------------
module tb_fadd_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [8:0]  result_i;
  logic [4:0]  fflags_i;
  logic [15:0] ctrl_c_i;
  logic [7:0]  ctrl_reg_idxw_i;
  logic [3:0]  ctrl_warpid_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [8:0]  wb_data_o;
  logic [15:0] wb_ctrl_c_o;
  logic [7:0]  wb_reg_idxw_o;
  logic [3:0]  wb_warpid_o;
  logic [2:0]  count_o;
  logic [3:0]  fflags_rd_warpid_i;
  logic [4:0]  fflags_rd_o;
  logic        fflags_clr_i;
  logic [3:0]  fflags_clr_warpid_i;

  int compared   = 0;
  int mismatched = 0;

  fadd_wb_queue dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .result_i            (result_i),
    .fflags_i            (fflags_i),
    .ctrl_c_i            (ctrl_c_i),
    .ctrl_reg_idxw_i     (ctrl_reg_idxw_i),
    .ctrl_warpid_i       (ctrl_warpid_i),
    .wb_valid_o          (wb_valid_o),
    .wb_ready_i          (wb_ready_i),
    .wb_data_o           (wb_data_o),
    .wb_ctrl_c_o         (wb_ctrl_c_o),
    .wb_reg_idxw_o       (wb_reg_idxw_o),
    .wb_warpid_o         (wb_warpid_o),
    .count_o             (count_o),
    .fflags_rd_warpid_i  (fflags_rd_warpid_i),
    .fflags_rd_o         (fflags_rd_o),
    .fflags_clr_i        (fflags_clr_i),
    .fflags_clr_warpid_i (fflags_clr_warpid_i)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the upstream result and the writeback ready together
  task automatic applyStimulus(input logic valid, input logic [8:0] data,
                               input logic [4:0] flags, input logic [7:0] reg_idx,
                               input logic [3:0] warp, input logic wb_ready);
    in_valid_i      = valid;
    result_i        = data;
    fflags_i        = flags;
    ctrl_c_i        = {7'h5A, data};
    ctrl_reg_idxw_i = reg_idx;
    ctrl_warpid_i   = warp;
    wb_ready_i      = wb_ready;
  endtask

  task automatic checkSticky(input string tag, input logic [3:0] warp,
                             input logic [4:0] expected);
    fflags_rd_warpid_i = warp;
    #1;
    checkOutput(tag, 32'(fflags_rd_o), 32'(expected));
  endtask

  initial begin
    rst                 = 1'b1;
    fflags_rd_warpid_i  = '0;
    fflags_clr_i        = 1'b0;
    fflags_clr_warpid_i = '0;
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    checkOutput("reset_in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("reset_wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("reset_count",    32'(count_o),    32'd0);
    checkOutput("reset_wb_data",  32'(wb_data_o),  32'd0);
    for (int w = 0; w < 16; w++) checkSticky("reset_sticky", 4'(w), 5'b0);

    // Single entry through an empty queue: visible the next cycle
    applyStimulus(1'b1, 9'h0A8, 5'b00001, 8'h12, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b1);
    checkOutput("single_valid",  32'(wb_valid_o),    32'd1);
    checkOutput("single_data",   32'(wb_data_o),     32'h0A8);
    checkOutput("single_reg",    32'(wb_reg_idxw_o), 32'h12);
    checkOutput("single_warp",   32'(wb_warpid_o),   32'd3);
    checkOutput("single_ctrl_c", 32'(wb_ctrl_c_o),   32'hB4A8);
    checkOutput("single_count",  32'(count_o),       32'd1);
    tick();
    checkOutput("single_count0", 32'(count_o),       32'd0);
    checkOutput("single_valid0", 32'(wb_valid_o),    32'd0);
    checkSticky("sticky3_first", 4'd3, 5'b00001);

    // Second warp-3 entry accumulates into the same sticky register
    applyStimulus(1'b1, 9'h101, 5'b00100, 8'h13, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b1);
    tick();
    checkSticky("sticky3_accum", 4'd3, 5'b00101);
    checkSticky("sticky0_clean", 4'd0, 5'b00000);
    checkSticky("sticky2_clean", 4'd2, 5'b00000);

    // Fill while stalled: values 1..5, only four fit
    for (int v = 1; v <= 4; v++) begin
      applyStimulus(1'b1, 9'(v), 5'b0, 8'(v), 4'd1, 1'b0);
      checkOutput("fill_ready", 32'(in_ready_o), 32'd1);
      tick();
    end
    applyStimulus(1'b1, 9'd5, 5'b0, 8'd5, 4'd1, 1'b0);
    checkOutput("full_count", 32'(count_o),    32'd4);
    checkOutput("full_ready", 32'(in_ready_o), 32'd0);
    checkOutput("full_head",  32'(wb_data_o),  32'd1);
    tick();
    checkOutput("stall_count", 32'(count_o),   32'd4);
    checkOutput("stall_hold",  32'(wb_data_o), 32'd1);
    // First pop: full, so value 5 is still refused this cycle
    wb_ready_i = 1'b1;
    tick();
    checkOutput("after_pop_count", 32'(count_o),    32'd3);
    checkOutput("after_pop_ready", 32'(in_ready_o), 32'd1);
    checkOutput("order_2",         32'(wb_data_o),  32'd2);
    tick();
    in_valid_i = 1'b0;
    checkOutput("push5_count", 32'(count_o),   32'd3);
    checkOutput("order_3",     32'(wb_data_o), 32'd3);
    tick();
    checkOutput("order_4",     32'(wb_data_o), 32'd4);
    tick();
    checkOutput("order_5",     32'(wb_data_o), 32'd5);
    tick();
    checkOutput("drain_count", 32'(count_o),    32'd0);
    checkOutput("drain_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("empty_hold",  32'(wb_data_o),  32'd5);

    // Steady occupancy of two with simultaneous push and pop
    applyStimulus(1'b1, 9'h010, 5'b0, 8'h20, 4'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 9'h011, 5'b0, 8'h21, 4'd1, 1'b0);
    tick();
    checkOutput("steady_start", 32'(count_o), 32'd2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 9'(18 + i), 5'b0, 8'(i), 4'd1, 1'b1);
      checkOutput("steady_data", 32'(wb_data_o), 32'(16 + i));
      tick();
      checkOutput("steady_count", 32'(count_o), 32'd2);
    end
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b1);
    checkOutput("steady_tail0", 32'(wb_data_o), 32'd24);
    tick();
    checkOutput("steady_tail1", 32'(wb_data_o), 32'd25);
    tick();
    checkOutput("steady_empty", 32'(count_o), 32'd0);

    // Clear and pop on warp 3 in the same cycle
    applyStimulus(1'b1, 9'h0C0, 5'b00010, 8'h30, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b1);
    fflags_clr_i        = 1'b1;
    fflags_clr_warpid_i = 4'd3;
    tick();
    fflags_clr_i = 1'b0;
    checkSticky("clr_pop_warp3", 4'd3, 5'b00010);

    // Warp 7 gets flags, then a plain clear wipes them
    applyStimulus(1'b1, 9'h0C1, 5'b10000, 8'h31, 4'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b1);
    tick();
    checkSticky("sticky7_set", 4'd7, 5'b10000);
    fflags_clr_i        = 1'b1;
    fflags_clr_warpid_i = 4'd7;
    tick();
    fflags_clr_i = 1'b0;
    checkSticky("sticky7_clr", 4'd7, 5'b00000);
    checkSticky("sticky3_kept", 4'd3, 5'b00010);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 9'(9'h1E0 + i), 5'b11111, 8'h40, 4'd5, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b0);
    checkOutput("pre_rst_count", 32'(count_o), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_count",    32'(count_o),    32'd0);
    checkOutput("rst_valid",    32'(wb_valid_o), 32'd0);
    checkOutput("rst_ready",    32'(in_ready_o), 32'd1);
    checkOutput("rst_wb_data",  32'(wb_data_o),  32'd0);
    for (int w = 0; w < 16; w++) checkSticky("rst_sticky", 4'(w), 5'b0);
    applyStimulus(1'b1, 9'h055, 5'b0, 8'h50, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 9'h000, 5'b0, 8'h00, 4'd0, 1'b0);
    checkOutput("post_rst_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("post_rst_data",  32'(wb_data_o),  32'h055);
    checkOutput("post_rst_count", 32'(count_o),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
